// File: rtl/stop_watch_datapath.sv
// Stopwatch timekeeping datapath.
// A prescaler divides the system clock down to the centisecond rate. Each
// prescaler terminal count advances a centisecond/second/minute/hour cascade,
// with every carry resolved on the same clock edge. The clear input zeroes all
// state, and it overrides counting. When run_stop is low, the prescaler phase
// and all fields are frozen, so counting resumes with no time lost or gained.
// All outputs come straight from registers.
module stop_watch_datapath #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_stop,
    input  logic       clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_tick,
    output logic       o_rollover
);

    // Prescaler terminal count. DIV must be at least 2 for the prescaler to
    // have a meaningful width.
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    msec_q,  msec_d;
    logic [5:0]    sec_q,   sec_d;
    logic [5:0]    min_q,   min_d;
    logic [4:0]    hour_q,  hour_d;
    logic          tick_q,  tick_d;
    logic          roll_q,  roll_d;

    // Next-state logic. Clear overrides counting, and counting overrides hold.
    // Each field wraps at its terminal value or at any larger value, so a
    // corrupted field cannot get stuck out of range.
    always_comb begin
        presc_d = presc_q;
        msec_d  = msec_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        tick_d  = 1'b0;
        roll_d  = 1'b0;

        if (clear) begin
            presc_d = '0;
            msec_d  = '0;
            sec_d   = '0;
            min_d   = '0;
            hour_d  = '0;
        end else if (run_stop) begin
            if (presc_q >= PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (msec_q >= 7'd99) begin
                    msec_d = '0;
                    if (sec_q >= 6'd59) begin
                        sec_d = '0;
                        if (min_q >= 6'd59) begin
                            min_d = '0;
                            if (hour_q >= 5'd23) begin
                                hour_d = '0;
                                roll_d = 1'b1;
                            end else begin
                                hour_d = hour_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    msec_d = msec_q + 7'd1;
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            msec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            tick_q  <= 1'b0;
            roll_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            tick_q  <= tick_d;
            roll_q  <= roll_d;
        end
    end

    assign o_msec     = msec_q;
    assign o_sec      = sec_q;
    assign o_min      = min_q;
    assign o_hour     = hour_q;
    assign o_tick     = tick_q;
    assign o_rollover = roll_q;

endmodule

// File: tb/tb_stop_watch_datapath.sv
// Testbench for stop_watch_datapath.
// The reference model keeps the elapsed time as one total centisecond count
// plus a prescaler phase. Each displayed field is derived from that total by
// division and modulo.
module tb_stop_watch_datapath;

  localparam int CLK_FREQ = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int DAY_CS   = 24 * 60 * 60 * 100;
  localparam int W        = 26;

  logic       clk;
  logic       reset;
  logic       run_stop;
  logic       clear;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;
  logic       o_rollover;

  stop_watch_datapath #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_stop  (run_stop),
    .clear     (clear),
    .o_msec    (o_msec),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_hour    (o_hour),
    .o_tick    (o_tick),
    .o_rollover(o_rollover)
  );

  // Clock and input initialisation.
  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    run_stop = 1'b0;
    clear    = 1'b0;
  end
  always #5 clk = ~clk;

  // Scoreboard and reference model state.
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cs_total = 0;
  int phase = 0;

  // Advances the reference model by one clock edge and queues the expected
  // outputs in the order {hour, min, sec, msec, tick, rollover}.
  task automatic model_update(input logic r, input logic c, input logic rs);
    logic m_tick;
    logic m_roll;
    m_tick = 1'b0;
    m_roll = 1'b0;
    if (r || c) begin
      cs_total = 0;
      phase    = 0;
    end else if (rs) begin
      phase = phase + 1;
      if (phase == DIV) begin
        phase    = 0;
        m_tick   = 1'b1;
        cs_total = cs_total + 1;
        if (cs_total == DAY_CS) begin
          cs_total = 0;
          m_roll   = 1'b1;
        end
      end
    end
    exp_q.push_back({5'(cs_total / 360000), 6'((cs_total / 6000) % 60),
                     6'((cs_total / 100) % 60), 7'(cs_total % 100), m_tick, m_roll});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compares the DUT outputs against the oldest queued model expectation.
  task automatic scoreboard_check();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {o_hour, o_min, o_sec, o_msec, o_tick, o_rollover};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: expected queue empty (t=%0t)", $time);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL model: got %0d:%0d:%0d.%0d tick=%0d roll=%0d expected %0d:%0d:%0d.%0d tick=%0d roll=%0d (t=%0t)",
                 act[25:21], act[20:15], act[14:9], act[8:2], act[1], act[0],
                 exp[25:21], exp[20:15], exp[14:9], exp[8:2], exp[1], exp[0], $time);
      end
    end
  endtask

  // Driver: apply inputs at the negedge, let one posedge pass, then check at
  // the following negedge.
  task automatic step(input logic r, input logic c, input logic rs);
    reset    = r;
    clear    = c;
    run_stop = rs;
    @(posedge clk);
    model_update(r, c, rs);
    @(negedge clk);
    scoreboard_check();
  endtask

  task automatic run_n(input int n, input logic r, input logic c, input logic rs);
    for (int i = 0; i < n; i++) step(r, c, rs);
  endtask

  // Loads a time of day into the count registers while holding, for corner
  // cases that are unreachable by counting within the cycle budget.
  task automatic preload(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                         input logic [6:0] cs);
    force dut.hour_q = h;
    force dut.min_q  = m;
    force dut.sec_q  = s;
    force dut.msec_q = cs;
    cs_total = ((32'(h) * 60 + 32'(m)) * 60 + 32'(s)) * 100 + 32'(cs);
    step(1'b0, 1'b0, 1'b0);
    release dut.hour_q;
    release dut.min_q;
    release dut.sec_q;
    release dut.msec_q;
  endtask

  typedef struct {
    logic       rst;
    logic       clr;
    logic       run;
    int         n;
    logic [6:0] msec;
    logic [5:0] sec;
    logic       tick;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{rst: 1, clr: 0, run: 1, n: 2,  msec: 0, sec: 0, tick: 0};
    vecs[1]  = '{rst: 0, clr: 0, run: 1, n: 9,  msec: 0, sec: 0, tick: 0};
    vecs[2]  = '{rst: 0, clr: 0, run: 1, n: 1,  msec: 1, sec: 0, tick: 1};
    vecs[3]  = '{rst: 0, clr: 0, run: 1, n: 15, msec: 2, sec: 0, tick: 0};
    vecs[4]  = '{rst: 0, clr: 0, run: 0, n: 40, msec: 2, sec: 0, tick: 0};
    vecs[5]  = '{rst: 0, clr: 0, run: 1, n: 4,  msec: 2, sec: 0, tick: 0};
    vecs[6]  = '{rst: 0, clr: 0, run: 1, n: 1,  msec: 3, sec: 0, tick: 1};
    vecs[7]  = '{rst: 0, clr: 1, run: 0, n: 1,  msec: 0, sec: 0, tick: 0};
    vecs[8]  = '{rst: 0, clr: 0, run: 1, n: 10, msec: 1, sec: 0, tick: 1};
    vecs[9]  = '{rst: 0, clr: 0, run: 1, n: 9,  msec: 1, sec: 0, tick: 0};
    vecs[10] = '{rst: 0, clr: 1, run: 1, n: 1,  msec: 0, sec: 0, tick: 0};
    vecs[11] = '{rst: 0, clr: 0, run: 1, n: 9,  msec: 0, sec: 0, tick: 0};
    vecs[12] = '{rst: 0, clr: 0, run: 1, n: 1,  msec: 1, sec: 0, tick: 1};
    vecs[13] = '{rst: 0, clr: 0, run: 1, n: 4,  msec: 1, sec: 0, tick: 0};
    vecs[14] = '{rst: 1, clr: 0, run: 1, n: 1,  msec: 0, sec: 0, tick: 0};

    @(negedge clk);

    // Table-driven phase: reset, first tick, hold/resume, clear, clear vs
    // terminal count, and reset mid-count.
    for (int v = 0; v < 15; v++) begin
      run_n(vecs[v].n, vecs[v].rst, vecs[v].clr, vecs[v].run);
      check($sformatf("vec%0d_msec", v), 32'(o_msec), 32'(vecs[v].msec));
      check($sformatf("vec%0d_sec", v),  32'(o_sec),  32'(vecs[v].sec));
      check($sformatf("vec%0d_tick", v), 32'(o_tick), 32'(vecs[v].tick));
    end

    // 100 ticks from zero: msec wraps and sec carries on the same edge.
    step(1'b0, 1'b1, 1'b0);
    run_n(100 * DIV, 1'b0, 1'b0, 1'b1);
    check("cascade100_msec", 32'(o_msec), 32'd0);
    check("cascade100_sec",  32'(o_sec),  32'd1);
    check("cascade100_tick", 32'(o_tick), 32'd1);

    // Count to 00:00:03.45, hold, then clear for one cycle.
    step(1'b0, 1'b1, 1'b0);
    run_n(345 * DIV, 1'b0, 1'b0, 1'b1);
    run_n(3, 1'b0, 1'b0, 1'b0);
    check("at345_sec",  32'(o_sec),  32'd3);
    check("at345_msec", 32'(o_msec), 32'd45);
    step(1'b0, 1'b1, 1'b0);
    check("clear_msec", 32'(o_msec), 32'd0);
    check("clear_sec",  32'(o_sec),  32'd0);
    run_n(DIV - 1, 1'b0, 1'b0, 1'b1);
    check("post_clear_no_tick", 32'(o_tick), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("post_clear_tick", 32'(o_tick), 32'd1);
    check("post_clear_msec", 32'(o_msec), 32'd1);

    // 00:00:59.99 -> 00:01:00.00
    step(1'b0, 1'b1, 1'b0);
    preload(5'd0, 6'd0, 6'd59, 7'd99);
    run_n(DIV, 1'b0, 1'b0, 1'b1);
    check("min_carry_min",  32'(o_min),  32'd1);
    check("min_carry_sec",  32'(o_sec),  32'd0);
    check("min_carry_msec", 32'(o_msec), 32'd0);

    // 00:59:59.99 -> 01:00:00.00
    step(1'b0, 1'b1, 1'b0);
    preload(5'd0, 6'd59, 6'd59, 7'd99);
    run_n(DIV, 1'b0, 1'b0, 1'b1);
    check("hour_carry_hour", 32'(o_hour), 32'd1);
    check("hour_carry_min",  32'(o_min),  32'd0);

    // 23:59:59.99 -> 00:00:00.00 with a one-cycle rollover pulse.
    step(1'b0, 1'b1, 1'b0);
    preload(5'd23, 6'd59, 6'd59, 7'd99);
    run_n(DIV, 1'b0, 1'b0, 1'b1);
    check("wrap_hour", 32'(o_hour), 32'd0);
    check("wrap_roll", 32'(o_rollover), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("wrap_roll_once", 32'(o_rollover), 32'd0);

    // Randomized phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7));
    end

    // Reset mid-count gives the same zero state as clear.
    run_n(37, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("reset_mid_msec", 32'(o_msec), 32'd0);
    check("reset_mid_sec",  32'(o_sec),  32'd0);
    check("reset_mid_min",  32'(o_min),  32'd0);
    check("reset_mid_hour", 32'(o_hour), 32'd0);
    check("reset_mid_tick", 32'(o_tick), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
